// File: rtl/exp4_fluxo_dados.sv
// exp4_fluxo_dados: memory-game datapath with address counter, 16x4 pattern ROM, play register,
// button press edge detector and saturating timeout counter. Define SYNC_BOTOES_EN to add a two-flop button synchronizer.
module exp4_fluxo_dados #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zerac,
    input  logic       contac,
    input  logic       zeraR,
    input  logic       registrarR,
    input  logic       zera_s_timeout,
    input  logic [3:0] botoes,
    output logic       fim,
    output logic       jogada_feita,
    output logic       igual,
    output logic       timeout,
    output logic [3:0] db_contagem,
    output logic [3:0] db_memoria,
    output logic [3:0] db_jogada,
    output logic       db_tem_jogada
);

    localparam logic [15:0] TIMEOUT_FIM = 16'(TIMEOUT_CICLOS - 1);

    logic [3:0]  contagem;
    logic [3:0]  jogada;
    logic [3:0]  memoria;
    logic [3:0]  b;
    logic        tem_jogada;
    logic        prev;
    logic        pulso;
    logic [15:0] conta_timeout;

    // Address counter: clear beats increment, wraps naturally at 4 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= 4'd0;
        end else if (zerac) begin
            contagem <= 4'd0;
        end else if (contac) begin
            contagem <= contagem + 4'd1;
        end
    end

    assign fim = (contagem == 4'd15);

    always_comb begin
        memoria = 4'd1;
        case (contagem)
            4'd0:  memoria = 4'd1;
            4'd1:  memoria = 4'd2;
            4'd2:  memoria = 4'd4;
            4'd3:  memoria = 4'd8;
            4'd4:  memoria = 4'd4;
            4'd5:  memoria = 4'd2;
            4'd6:  memoria = 4'd1;
            4'd7:  memoria = 4'd1;
            4'd8:  memoria = 4'd2;
            4'd9:  memoria = 4'd2;
            4'd10: memoria = 4'd4;
            4'd11: memoria = 4'd4;
            4'd12: memoria = 4'd8;
            4'd13: memoria = 4'd8;
            4'd14: memoria = 4'd1;
            4'd15: memoria = 4'd4;
            default: memoria = 4'd1;
        endcase
    end

`ifdef SYNC_BOTOES_EN
    logic [3:0] sync_1;
    logic [3:0] sync_2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 4'd0;
            sync_2 <= 4'd0;
        end else begin
            sync_1 <= botoes;
            sync_2 <= sync_1;
        end
    end

    assign b = sync_2;
`else
    assign b = botoes;
`endif

    assign tem_jogada = |b;

    // Play register loads whatever b holds at the edge, synchronized or not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada <= 4'd0;
        end else if (zeraR) begin
            jogada <= 4'd0;
        end else if (registrarR) begin
            jogada <= b;
        end
    end

    assign igual = (jogada == memoria);
    assign pulso = tem_jogada & ~prev;

    // Rising edge of "any button" gives a single pulse however long the press lasts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev         <= 1'b0;
            jogada_feita <= 1'b0;
        end else begin
            prev         <= tem_jogada;
            jogada_feita <= pulso;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conta_timeout <= 16'd0;
        end else if (zera_s_timeout) begin
            conta_timeout <= 16'd0;
        end else if (conta_timeout != TIMEOUT_FIM) begin
            conta_timeout <= conta_timeout + 16'd1;
        end
    end

    assign timeout       = (conta_timeout == TIMEOUT_FIM);
    assign db_contagem   = contagem;
    assign db_memoria    = memoria;
    assign db_jogada     = jogada;
    assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_exp4_fluxo_dados.sv
// Bench for exp4_fluxo_dados with TIMEOUT_CICLOS=10; works with SYNC_BOTOES_EN defined or not.
module tb_exp4_fluxo_dados;

    localparam int TO = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       zerac, contac, zeraR, registrarR, zera_s_timeout;
    logic [3:0] botoes;
    logic       fim, jogada_feita, igual, timeout, db_tem_jogada;
    logic [3:0] db_contagem, db_memoria, db_jogada;

    int n_cmp = 0;
    int n_err = 0;

    exp4_fluxo_dados #(.TIMEOUT_CICLOS(TO)) dut (
        .clock(clock), .reset(reset), .zerac(zerac), .contac(contac),
        .zeraR(zeraR), .registrarR(registrarR), .zera_s_timeout(zera_s_timeout),
        .botoes(botoes), .fim(fim), .jogada_feita(jogada_feita), .igual(igual),
        .timeout(timeout), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain arithmetic on the documented rules.
    int         rom [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};
    int         m_addr;
    logic [3:0] m_reg;
    int         m_since;      // cycles since last clear, unbounded
    logic [3:0] m_hist[$];    // botoes sampled at each edge since reset
    logic       m_any_last;
    logic       m_jf;

    logic [16:0] exp_q[$];

    function automatic logic [3:0] model_b();
`ifdef SYNC_BOTOES_EN
        return m_hist[m_hist.size() - 2];
`else
        return botoes;
`endif
    endfunction

    function automatic void model_reset();
        m_addr = 0;
        m_reg = 4'd0;
        m_since = 0;
        m_hist = '{4'd0, 4'd0};
        m_any_last = 1'b0;
        m_jf = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [3:0] b_old;
        b_old = model_b();
        m_jf = (|b_old) && !m_any_last;
        m_any_last = |b_old;
        if (zerac) m_addr = 0;
        else if (contac) m_addr = (m_addr + 1) % 16;
        if (zeraR) m_reg = 4'd0;
        else if (registrarR) m_reg = b_old;
        if (zera_s_timeout) m_since = 0;
        else m_since = m_since + 1;
        m_hist.push_back(botoes);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endfunction

    function automatic logic [16:0] model_out();
        logic [3:0] mem;
        mem = 4'(rom[m_addr]);
        return {m_addr == 15, m_jf, m_reg == mem, m_since >= TO - 1,
                4'(m_addr), mem, m_reg, |model_b()};
    endfunction

    function automatic void check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Driver: apply inputs after negedge, model the edge, compare at the next negedge.
    task automatic step(input logic zc, input logic ct, input logic zr, input logic rr,
                        input logic zt, input logic [3:0] bt);
        logic [16:0] act;
        logic [16:0] expv;
        zerac = zc; contac = ct; zeraR = zr; registrarR = rr;
        zera_s_timeout = zt; botoes = bt;
        @(posedge clock);
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clock);
        expv = exp_q.pop_front();
        act = {fim, jogada_feita, igual, timeout, db_contagem, db_memoria, db_jogada, db_tem_jogada};
        check("outputs", int'(act), int'(expv));
    endtask

    task automatic idle(input logic [3:0] bt);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bt);
    endtask

    typedef struct {
        logic       zc;
        logic       ct;
        logic [3:0] exp_cnt;
        logic       exp_fim;
    } cnt_vec_t;

    cnt_vec_t tv [17];

    initial begin
        int pulses;
        int to_seen;

        tv[0] = '{1'b1, 1'b0, 4'd0, 1'b0};
        for (int i = 1; i <= 15; i++) tv[i] = '{1'b0, 1'b1, 4'(i), i == 15};
        tv[16] = '{1'b0, 1'b1, 4'd0, 1'b0};

        reset = 1'b1;
        zerac = 0; contac = 0; zeraR = 0; registrarR = 0; zera_s_timeout = 0;
        botoes = 4'd0;
        model_reset();
        #1;
        check("reset_contagem", int'(db_contagem), 0);
        check("reset_memoria", int'(db_memoria), 1);
        check("reset_jogada", int'(db_jogada), 0);
        check("reset_fim_timeout_igual", int'({fim, timeout, igual, jogada_feita}), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Counter sweep from the vector table
        for (int i = 0; i < 17; i++) begin
            step(tv[i].zc, tv[i].ct, 1'b0, 1'b0, 1'b0, 4'd0);
            check("sweep_contagem", int'(db_contagem), int'(tv[i].exp_cnt));
            check("sweep_fim", int'(fim), int'(tv[i].exp_fim));
        end

        // Single press held, register capture, clear beats load
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, i == 4, 1'b0, 4'b1000);
            pulses += int'(jogada_feita);
        end
        check("held_jogada", int'(db_jogada), 8);
        check("held_igual", int'(igual), 1);
        for (int i = 0; i < 4; i++) begin
            idle(4'd0);
            pulses += int'(jogada_feita);
        end
        check("held_one_pulse", pulses, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100);
        check("zeraR_priority", int'(db_jogada), 0);
        check("zeraR_igual", int'(igual), 0);
        for (int i = 0; i < 4; i++) idle(4'd0);

        // Timeout reaches terminal 9 cycles after clear and holds
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("to_after_clear", int'(timeout), 0);
        for (int k = 1; k <= 9; k++) begin
            idle(4'd0);
            check("to_rise", int'(timeout), int'(k == 9));
        end
        to_seen = 1;
        for (int k = 0; k < 20; k++) begin
            idle(4'd0);
            to_seen &= int'(timeout);
        end
        check("to_hold", to_seen, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("to_cleared", int'(timeout), 0);

        // Counter at 8, then cleared every 5 cycles: never reaches terminal
        for (int k = 0; k < 8; k++) idle(4'd0);
        to_seen = 0;
        for (int r = 0; r < 6; r++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
            to_seen |= int'(timeout);
            for (int k = 0; k < 4; k++) begin
                idle(4'd0);
                to_seen |= int'(timeout);
            end
        end
        check("to_never", to_seen, 0);

        // Two presses separated by one idle cycle
        pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001); pulses += int'(jogada_feita);
        idle(4'd0);                                  pulses += int'(jogada_feita);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010); pulses += int'(jogada_feita);
        for (int k = 0; k < 5; k++) begin
            idle(4'd0);
            pulses += int'(jogada_feita);
        end
        check("two_pulses", pulses, 2);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] bt;
            int sel;
            sel = $urandom_range(0, 5);
            bt = (sel < 4) ? 4'(1 << sel) : 4'd0;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 13) == 0, bt);
        end

        // Asynchronous reset mid-count: address 7, timeout count 6, play register 2
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0, k == 6, k == 0, 4'b0010);
        check("pre_reset_contagem", int'(db_contagem), 7);
        check("pre_reset_jogada", int'(db_jogada), 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_contagem", int'(db_contagem), 0);
        check("async_jogada", int'(db_jogada), 0);
        check("async_memoria", int'(db_memoria), 1);
        check("async_flags", int'({fim, timeout, igual, jogada_feita}), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            idle(4'b0010);
            pulses += int'(jogada_feita);
        end
        check("held_over_reset", pulses, 1);
        for (int k = 0; k < 3; k++) idle(4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
